clear_ctrl_fsm: RTL and testbench
=================================

// Module: clear_ctrl_fsm
// PURPOSE
//  Control FSM directly upstream of the memory-clear datapath. Accepts host commands over a
//  valid/ready handshake and drives ld_high/ld_low/write/ld_cnt/cnt_en/addr_sel/zero_we/
//  set_busy/clr_busy, consuming cnt_eq. Sequences block-clear (zero-fill) of memory range
//  [low..high] with abort, bounds check, watchdog timeout and completion status.
// PARAMETERS
//  ADDRWIDTH  6               datapath address width; sets watchdog width and limit
//  TIMEOUT    2**ADDRWIDTH+1  max CLEAR-state cycles before timeout error
// PORTS
//  clock      in   1   single system clock, rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  cmd_valid  in   1   host command valid
//  cmd        in   2   00 WRITE, 01 LOAD_LOW, 10 LOAD_HIGH, 11 CLEAR
//  cmd_ready  out  1   command accepted when cmd_valid && cmd_ready
//  abort      in   1   level; terminates a running clear
//  cnt_eq     in   1   from datapath: counter == high bound
//  ld_low     out  1   load low-bound register (datapath)
//  ld_high    out  1   load high-bound register
//  write      out  1   host write strobe to memory
//  ld_cnt     out  1   load counter from low bound
//  cnt_en     out  1   counter increment
//  addr_sel   out  1   1 = counter address / zero data; 0 = host address / din
//  zero_we    out  1   zero-fill write enable
//  set_busy   out  1   set busy flag (J)
//  clr_busy   out  1   clear busy flag (K)
//  done       out  1   1-cycle pulse at end of every CLEAR command
//  status     out  2   valid with done: 00 OK, 01 ABORTED, 10 NOBOUNDS, 11 TIMEOUT
// BEHAVIOUR
//  States: RST_CLR, IDLE, START, CLEAR, FINISH. All datapath outputs are combinational
//   decodes of state (+cnt_eq, +accepted cmd in IDLE); status is registered.
//  Reset (reset_n=0): state=RST_CLR, low_vld=high_vld=0, status=00, watchdog=0. In RST_CLR,
//   clr_busy=1; every other output is 0, including cmd_ready. The busy FF has no reset, so
//   this state initializes it. RST_CLR -> IDLE unconditionally on the first edge.
//  IDLE: cmd_ready=1. On an accepted command:
//   WRITE, LOAD_LOW, LOAD_HIGH -> write, ld_low or ld_high =1 in the same cycle (Mealy),
//    addr_sel=0, stay IDLE. LOAD_LOW sets low_vld; LOAD_HIGH sets high_vld (sticky to reset).
//   CLEAR with low_vld && high_vld -> START.
//   CLEAR without both flags -> FINISH, status<=10, no memory writes.
//   abort is ignored in IDLE.
//  START (1 cycle): ld_cnt=1, set_busy=1, addr_sel=1, cmd_ready=0; watchdog<=0.
//   abort=1 -> FINISH, status<=01, no zero_we issued. Else -> CLEAR.
//  CLEAR: addr_sel=1, zero_we=1, cnt_en=~cnt_eq, cmd_ready=0; watchdog increments.
//   cnt_eq=1 -> FINISH, status<=00. The final word is written this cycle.
//   cnt_eq wins over abort and timeout in the same cycle.
//   else abort=1 -> FINISH, status<=01 (the word written this cycle stays written).
//   else watchdog==TIMEOUT-1 -> FINISH, status<=11.
//  FINISH (1 cycle): clr_busy=1, done=1, cmd_ready=0 -> IDLE.
//  Latency: CLEAR accepted at cycle T -> START at T+1, first zero_we at T+2.
//   zero_we cycles N = ((high-low) mod 2**ADDRWIDTH)+1; done at T+2+N.
//  Wrap-around: low>high wraps through the top address to high; this is legal, not an error.
//   low==high gives N=1.
//  Watchdog: ADDRWIDTH+1 bits, compared against TIMEOUT-1; it cannot fire with a correct datapath.
//  Reset mid-clear: state goes to RST_CLR immediately (async). zero_we and cnt_en drop at once.
//   Bound flags clear; memory contents are undefined for the interrupted range.
// TESTING
//  1 reset, LOAD_LOW a=3, LOAD_HIGH a=5, CLEAR -> zero_we at T+2..T+4, done T+5, status 00, busy 0 after
//  2 CLEAR right after reset (no bounds) -> no zero_we, done at T+1, status 10, busy stays 0
//  3 low=62, high=1 -> N=4 zero writes at addr 62,63,0,1; status 00; other words untouched
//  4 low=0, high=63, abort at 5th CLEAR cycle -> 5 words zeroed, done next cycle, status 01
//  5 tie cnt_eq=0 (fault model) -> status 11 after exactly TIMEOUT CLEAR cycles; abort with cnt_eq same cycle -> status 00
//  6 reset_n low mid-clear -> outputs drop async, clr_busy=1, then IDLE cmd_ready=1; CLEAR -> status 10

Source files
------------

// File: rtl/clear_ctrl_fsm_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clear_ctrl_fsm_if                                             |
// | Brief    : Host command channel of the memory-clear controller.          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface clear_ctrl_fsm_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       abort;
    logic       done;
    logic [1:0] status;

    modport master (
        output cmd_valid, cmd, abort,
        input  cmd_ready, done, status
    );

    modport slave (
        input  cmd_valid, cmd, abort,
        output cmd_ready, done, status
    );
endinterface
`default_nettype wire

// File: rtl/clear_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clear_ctrl_fsm                                                |
// | Brief    : Sequences host writes, bound loads and block zero-fill of the |
// |            memory range [low..high] with abort, bounds check and timeout.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module clear_ctrl_fsm #(
    parameter int ADDRWIDTH = 6,
    parameter int TIMEOUT   = 2**ADDRWIDTH + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    clear_ctrl_fsm_if.slave        host,
    input  logic                   cnt_eq_i,
    output logic                   ld_low_o,
    output logic                   ld_high_o,
    output logic                   write_o,
    output logic                   ld_cnt_o,
    output logic                   cnt_en_o,
    output logic                   addr_sel_o,
    output logic                   zero_we_o,
    output logic                   set_busy_o,
    output logic                   clr_busy_o
);

    localparam int WD_W = ADDRWIDTH + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [1:0] CMD_WRITE     = 2'b00;
    localparam logic [1:0] CMD_LOAD_LOW  = 2'b01;
    localparam logic [1:0] CMD_LOAD_HIGH = 2'b10;
    localparam logic [1:0] CMD_CLEAR     = 2'b11;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_ABORTED  = 2'b01;
    localparam logic [1:0] ST_NOBOUNDS = 2'b10;
    localparam logic [1:0] ST_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        S_RST_CLR = 3'd0,
        S_IDLE    = 3'd1,
        S_START   = 3'd2,
        S_CLEAR   = 3'd3,
        S_FINISH  = 3'd4
    } state_e;

    state_e            state_q;
    logic              low_vld_q;
    logic              high_vld_q;
    logic [1:0]        status_q;
    logic [WD_W-1:0]   wdog_q;
    logic              accept;

    assign accept = host.cmd_valid && (state_q == S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_RST_CLR;
            low_vld_q  <= 1'b0;
            high_vld_q <= 1'b0;
            status_q   <= ST_OK;
            wdog_q     <= '0;
        end else begin
            case (state_q)
                S_RST_CLR: state_q <= S_IDLE;
                S_IDLE: begin
                    if (accept) begin
                        case (host.cmd)
                            CMD_LOAD_LOW:  low_vld_q  <= 1'b1;
                            CMD_LOAD_HIGH: high_vld_q <= 1'b1;
                            CMD_CLEAR: begin
                                if (low_vld_q && high_vld_q) begin
                                    state_q <= S_START;
                                end else begin
                                    state_q  <= S_FINISH;
                                    status_q <= ST_NOBOUNDS;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_START: begin
                    wdog_q <= '0;
                    if (host.abort) begin
                        state_q  <= S_FINISH;
                        status_q <= ST_ABORTED;
                    end else begin
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    wdog_q <= wdog_q + 1'b1;
                    // Reaching the high bound takes priority: the last word is already written.
                    if (cnt_eq_i) begin
                        state_q  <= S_FINISH;
                        status_q <= ST_OK;
                    end else if (host.abort) begin
                        state_q  <= S_FINISH;
                        status_q <= ST_ABORTED;
                    end else if (wdog_q == WD_LAST) begin
                        state_q  <= S_FINISH;
                        status_q <= ST_TIMEOUT;
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_RST_CLR;
            endcase
        end
    end

    always_comb begin
        host.cmd_ready = 1'b0;
        host.done      = 1'b0;
        ld_low_o       = 1'b0;
        ld_high_o      = 1'b0;
        write_o        = 1'b0;
        ld_cnt_o       = 1'b0;
        cnt_en_o       = 1'b0;
        addr_sel_o     = 1'b0;
        zero_we_o      = 1'b0;
        set_busy_o     = 1'b0;
        clr_busy_o     = 1'b0;
        case (state_q)
            S_RST_CLR: clr_busy_o = 1'b1;
            S_IDLE: begin
                host.cmd_ready = 1'b1;
                write_o        = accept && (host.cmd == CMD_WRITE);
                ld_low_o       = accept && (host.cmd == CMD_LOAD_LOW);
                ld_high_o      = accept && (host.cmd == CMD_LOAD_HIGH);
            end
            S_START: begin
                ld_cnt_o   = 1'b1;
                set_busy_o = 1'b1;
                addr_sel_o = 1'b1;
            end
            S_CLEAR: begin
                addr_sel_o = 1'b1;
                zero_we_o  = 1'b1;
                cnt_en_o   = ~cnt_eq_i;
            end
            S_FINISH: begin
                clr_busy_o = 1'b1;
                host.done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign host.status = status_q;

endmodule
`default_nettype wire

// File: tb/tb_clear_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_clear_ctrl_fsm                                             |
// | Brief    : Self-checking bench for clear_ctrl_fsm with a datapath model. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_clear_ctrl_fsm;
    localparam int AW    = 6;
    localparam int DEPTH = 2**AW;
    localparam int TO    = DEPTH + 1;
    localparam logic [1:0] C_WRITE = 2'b00, C_LOW = 2'b01, C_HIGH = 2'b10, C_CLEAR = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clear_ctrl_fsm_if h();
    logic cnt_eq, ld_low, ld_high, wr, ld_cnt, cnt_en, addr_sel, zero_we, set_busy, clr_busy;

    clear_ctrl_fsm #(.ADDRWIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .host(h), .cnt_eq_i(cnt_eq),
        .ld_low_o(ld_low), .ld_high_o(ld_high), .write_o(wr), .ld_cnt_o(ld_cnt),
        .cnt_en_o(cnt_en), .addr_sel_o(addr_sel), .zero_we_o(zero_we),
        .set_busy_o(set_busy), .clr_busy_o(clr_busy)
    );

    // Datapath the controller drives: bound regs, counter, memory and a reset-less busy JK flop.
    logic [AW-1:0] hw_addr;
    logic [7:0]    hw_din;
    logic [AW-1:0] dp_low, dp_high, dp_cnt;
    logic [7:0]    dp_mem [DEPTH];
    logic          dp_busy;
    logic          fault;

    assign cnt_eq = !fault && (dp_cnt == dp_high);

    always @(posedge clk) begin
        if (ld_low)  dp_low  <= hw_addr;
        if (ld_high) dp_high <= hw_addr;
        if (wr)      dp_mem[hw_addr] <= hw_din;
        if (ld_cnt)      dp_cnt <= dp_low;
        else if (cnt_en) dp_cnt <= dp_cnt + 1'b1;
        if (zero_we) dp_mem[dp_cnt] <= 8'h00;
        if (set_busy)      dp_busy <= 1'b1;
        else if (clr_busy) dp_busy <= 1'b0;
    end

    // Reference: what memory and bounds must look like from the host's point of view.
    int ref_mem [DEPTH];
    int ref_low, ref_high;
    bit ref_low_vld, ref_high_vld;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_cmd(input logic [1:0] c, input int a, input int d);
        @(negedge clk);
        h.cmd_valid = 1'b1;
        h.cmd       = c;
        hw_addr     = AW'(a);
        hw_din      = 8'(d);
        #1;
        check("idle_ready", 32'(h.cmd_ready), 1);
        check("strobe_low", 32'(ld_low), 32'(c == C_LOW));
        check("strobe_high", 32'(ld_high), 32'(c == C_HIGH));
        check("strobe_write", 32'(wr), 32'(c == C_WRITE));
        check("host_addr_sel", 32'(addr_sel), 0);
        @(posedge clk);
        #1 h.cmd_valid = 1'b0;
        case (c)
            C_WRITE: ref_mem[a] = d;
            C_LOW:   begin ref_low = a;  ref_low_vld = 1'b1; end
            C_HIGH:  begin ref_high = a; ref_high_vld = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic fill_mem();
        for (int a = 0; a < DEPTH; a++) host_cmd(C_WRITE, a, int'($urandom_range(1, 255)));
    endtask

    task automatic set_bounds(input int lo, input int hi);
        host_cmd(C_LOW, lo, 0);
        host_cmd(C_HIGH, hi, 0);
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int a = 0; a < DEPTH; a++) if (int'(dp_mem[a]) != ref_mem[a]) bad++;
        check(tag, 32'(bad), 0);
    endtask

    // abort_cyc: cycle offset after command acceptance during which abort is held (0 = never).
    task automatic run_clear(input string tag, input int abort_cyc);
        int n_full, limit, k_ab, exp_writes, exp_done, seen_writes, done_at, done_cnt;
        logic [1:0] exp_st, seen_st;
        n_full = (((ref_high - ref_low) % DEPTH) + DEPTH) % DEPTH + 1;
        limit  = fault ? TO : n_full;
        k_ab   = (abort_cyc >= 2) ? abort_cyc - 1 : 0;
        if (!(ref_low_vld && ref_high_vld)) begin
            exp_writes = 0; exp_st = 2'b10;
        end else if (abort_cyc == 1) begin
            exp_writes = 0; exp_st = 2'b01;
        end else if (k_ab != 0 && (k_ab < limit || (fault && k_ab == limit))) begin
            exp_writes = k_ab; exp_st = 2'b01;
        end else begin
            exp_writes = limit; exp_st = fault ? 2'b11 : 2'b00;
        end
        exp_done = (exp_st == 2'b10) ? 1 : exp_writes + 2;

        @(negedge clk);
        h.cmd_valid = 1'b1;
        h.cmd       = C_CLEAR;
        #1 check({tag, "_ready"}, 32'(h.cmd_ready), 1);
        @(posedge clk);
        #1 h.cmd_valid = 1'b0;
        seen_writes = 0; done_at = 0; done_cnt = 0; seen_st = 2'b00;
        for (int c = 1; c <= TO + 10; c++) begin
            @(negedge clk);
            if (zero_we) seen_writes++;
            if (h.done) begin
                done_cnt++;
                if (done_at == 0) begin done_at = c; seen_st = h.status; end
            end
            if (c == 2 && exp_writes > 0) begin
                check({tag, "_busy_mid"}, 32'(dp_busy), 1);
                check({tag, "_ready_mid"}, 32'(h.cmd_ready), 0);
            end
            h.abort = (c == abort_cyc);
            if (done_at != 0 && c > done_at) break;
        end
        h.abort = 1'b0;
        check({tag, "_writes"}, 32'(seen_writes), 32'(exp_writes));
        check({tag, "_done_at"}, 32'(done_at), 32'(exp_done));
        check({tag, "_done_cnt"}, 32'(done_cnt), 1);
        check({tag, "_status"}, 32'(seen_st), 32'(exp_st));
        check({tag, "_busy_after"}, 32'(dp_busy), 0);
        check({tag, "_ready_after"}, 32'(h.cmd_ready), 1);
        for (int i = 0; i < exp_writes; i++) ref_mem[(ref_low + i) % DEPTH] = 0;
        check_mem({tag, "_mem"});
    endtask

    initial begin
        int lo, hi, n, ab;
        h.cmd_valid = 1'b0; h.cmd = 2'b00; h.abort = 1'b0;
        hw_addr = '0; hw_din = '0; fault = 1'b0;
        ref_low_vld = 1'b0; ref_high_vld = 1'b0; ref_low = 0; ref_high = 0;

        repeat (3) @(negedge clk);
        check("rst_clr_busy", 32'(clr_busy), 1);
        check("rst_ready", 32'(h.cmd_ready), 0);
        check("rst_zero_we", 32'(zero_we), 0);
        check("rst_done", 32'(h.done), 0);
        check("rst_status", 32'(h.status), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(h.cmd_ready), 1);
        check("post_rst_busy", 32'(dp_busy), 0);

        fill_mem();
        run_clear("nobounds", 0);

        set_bounds(3, 5);
        run_clear("basic", 0);

        set_bounds(62, 1);
        run_clear("wrap", 0);

        set_bounds(20, 20);
        run_clear("single", 0);

        fill_mem();
        set_bounds(0, 63);
        run_clear("abort5", 6);

        run_clear("abort_start", 1);

        fill_mem();
        fault = 1'b1;
        set_bounds(10, 12);
        run_clear("timeout", 0);
        fault = 1'b0;

        fill_mem();
        set_bounds(40, 44);
        run_clear("abort_tie", 6);

        h.abort = 1'b1;
        host_cmd(C_WRITE, 7, 8'h5A);
        h.abort = 1'b0;
        check_mem("idle_abort_mem");

        for (int it = 0; it < 6; it++) begin
            fill_mem();
            lo = int'($urandom_range(0, DEPTH - 1));
            hi = int'($urandom_range(0, DEPTH - 1));
            set_bounds(lo, hi);
            n  = (((hi - lo) % DEPTH) + DEPTH) % DEPTH + 1;
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n + 2)) : 0;
            run_clear("rand", ab);
        end

        set_bounds(0, 63);
        @(negedge clk);
        h.cmd_valid = 1'b1; h.cmd = C_CLEAR;
        @(posedge clk);
        #1 h.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_zero_we_before", 32'(zero_we), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_zero_we", 32'(zero_we), 0);
        check("midrst_cnt_en", 32'(cnt_en), 0);
        check("midrst_clr_busy", 32'(clr_busy), 1);
        check("midrst_ready", 32'(h.cmd_ready), 0);
        ref_low_vld = 1'b0; ref_high_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle_ready", 32'(h.cmd_ready), 1);
        check("midrst_busy", 32'(dp_busy), 0);
        fill_mem();
        run_clear("midrst_clear", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
